// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out capture stage.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit).
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sipo_state_e;

    // XOR-reduce of the word; an even-parity bit must equal this value.
    function automatic logic parity_even(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input strobes and parallel valid/ready output of the deserializer.
// Optional feature macro: PARITY_CHECK_EN (adds parity_err).
interface sipo_deserializer_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             ser_in;
    logic             shift_en;
    logic             frame_start;
    logic             out_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] par_out;
    logic             out_valid;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;
`ifdef PARITY_CHECK_EN
    logic             parity_err;
`endif

    modport master (
        output ser_in, shift_en, frame_start, out_ready, clr_ovr,
`ifdef PARITY_CHECK_EN
        input  parity_err,
`endif
        input  par_out, out_valid, overrun, bit_cnt
    );

    modport slave (
        input  ser_in, shift_en, frame_start, out_ready, clr_ovr,
`ifdef PARITY_CHECK_EN
        output parity_err,
`endif
        output par_out, out_valid, overrun, bit_cnt
    );

endinterface

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready holding register with a sticky overrun flag.
// A word offered while the entry is full and not being drained is dropped.
module sipo_out_buf
    import sipo_pkg::*;
#(
    parameter int DW = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          out_ready,
    input  logic          clr_ovr,
    output logic [DW-1:0] data,
    output logic          valid,
    output logic          overrun
);

    logic room;
    assign room = !valid || out_ready;

    // Holding register: reload when there is room, otherwise drain on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load && room) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && out_ready) begin
            valid <= 1'b0;
        end
    end

    // Sticky overrun: a drop in the same cycle as clr_ovr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (load && !room) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out capture stage fed by the parallel-load shifter's q.
// Optional feature macro: PARITY_CHECK_EN (one even-parity bit after each word).
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic               clk,
    input logic               rst,
    sipo_deserializer_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0]    ST_IDLE   = 2'(IDLE);
    localparam logic [1:0]    ST_SHIFT  = 2'(SHIFT);
    localparam logic [1:0]    ST_PARITY = 2'(PARITY);
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
    localparam int DW = WIDTH + 1;
`else
    localparam int DW = WIDTH;
`endif

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx, shifted, word_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             load;
    logic             perr_nx;
    logic [DW-1:0]    buf_in, buf_out;

    // Shift register contents after sampling ser_in this cycle.
    always_comb begin
        if (MSB_FIRST) shifted = {shreg[WIDTH-2:0], bus.ser_in};
        else           shifted = {bus.ser_in, shreg[WIDTH-1:1]};
    end

    // Next-state logic; frame_start in any state restarts on bit 0.
    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        cnt_nx   = cnt;
        load     = 1'b0;
        word_nx  = shifted;
        perr_nx  = 1'b0;
        if (bus.frame_start) begin
            state_nx = ST_SHIFT;
            if (bus.shift_en) begin
                shreg_nx = shifted;
                cnt_nx   = CW'(1);
            end else begin
                cnt_nx   = '0;
            end
        end else begin
            case (state)
                ST_SHIFT: begin
                    if (bus.shift_en) begin
                        shreg_nx = shifted;
                        if (cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                            state_nx = ST_PARITY;
                            cnt_nx   = CW'(WIDTH);
`else
                            load     = 1'b1;
                            cnt_nx   = '0;
`endif
                        end else begin
                            cnt_nx = cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
`ifdef PARITY_CHECK_EN
                    if (bus.shift_en) begin
                        load     = 1'b1;
                        word_nx  = shreg;
                        perr_nx  = parity_even(16'(shreg)) ^ bus.ser_in;
                        cnt_nx   = '0;
                        state_nx = ST_SHIFT;
                    end
`else
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
`endif
                end
                default: ;
            endcase
        end
    end

    // FSM, shift register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
        end
    end

`ifdef PARITY_CHECK_EN
    assign buf_in         = {perr_nx, word_nx};
    assign bus.parity_err = buf_out[WIDTH];
`else
    assign buf_in = word_nx;
    logic unused_perr;
    assign unused_perr = perr_nx;
`endif

    sipo_out_buf #(.DW(DW)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (buf_in),
        .out_ready (bus.out_ready),
        .clr_ovr   (bus.clr_ovr),
        .data      (buf_out),
        .valid     (bus.out_valid),
        .overrun   (bus.overrun)
    );

    assign bus.par_out = buf_out[WIDTH-1:0];
    assign bus.bit_cnt = cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: an MSB-first and an LSB-first instance
// share one serial stream; expected words are queued as they are sent.
// Optional feature macro: PARITY_CHECK_EN (parity bit and parity_err checks).
module tb_sipo_deserializer;

    logic clk, rst;
    logic ser_in, shift_en, frame_start, out_ready, clr_ovr;
    int   npass = 0;
    int   ntot  = 0;
    logic [8:0] q_exp[$];   // {parity_err, word as sent MSB-first}

    sipo_deserializer_if #(.WIDTH(8)) bus_m ();
    sipo_deserializer_if #(.WIDTH(8)) bus_l ();

    assign bus_m.ser_in = ser_in;       assign bus_l.ser_in = ser_in;
    assign bus_m.shift_en = shift_en;   assign bus_l.shift_en = shift_en;
    assign bus_m.frame_start = frame_start; assign bus_l.frame_start = frame_start;
    assign bus_m.out_ready = out_ready; assign bus_l.out_ready = out_ready;
    assign bus_m.clr_ovr = clr_ovr;     assign bus_l.clr_ovr = clr_ovr;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m));
    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rev8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) rev8[i] = w[7-i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Send bits lo..hi of w (w[7] goes on the wire first). par: 0/1 explicit
    // parity bit, 2 correct parity, 3 no parity bit (parity build only).
    task automatic send_bits(input logic [7:0] w, input int lo, input int hi,
                             input bit start, input int par);
        for (int i = lo; i <= hi; i++) begin
            ser_in = w[7-i]; shift_en = 1'b1; frame_start = start && (i == lo);
            tick();
        end
`ifdef PARITY_CHECK_EN
        if (hi == 7 && par != 3) begin
            ser_in = (par == 2) ? ^w : par[0]; shift_en = 1'b1; frame_start = 1'b0;
            tick();
        end
`endif
        shift_en = 1'b0; frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit start, input int par, input bit push);
        logic pbit;
        pbit = (par == 2) ? ^w : par[0];
        send_bits(w, 0, 7, start, par);
        if (push) q_exp.push_back({pbit ^ (^w), w});
    endtask

    // Wait (bounded) for a word, then compare both instances with the queue head.
    task automatic pop_check(input string tag);
        logic [8:0] e;
        for (int i = 0; i < 20 && !bus_m.out_valid; i++) tick();
        chk({tag, "_valid"}, bus_m.out_valid, 1);
        chk({tag, "_valid_l"}, bus_l.out_valid, 1);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : 9'h1xx;
        chk({tag, "_msb"}, bus_m.par_out, e[7:0]);
        chk({tag, "_lsb"}, bus_l.par_out, rev8(e[7:0]));
`ifdef PARITY_CHECK_EN
        chk({tag, "_perr"}, bus_m.parity_err, e[8]);
        chk({tag, "_perr_l"}, bus_l.parity_err, e[8]);
`endif
    endtask

    task automatic consume();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ser_in = 0; shift_en = 0; frame_start = 0; out_ready = 0; clr_ovr = 0;
        tick(); tick();
        rst = 1'b0;
        chk("init_valid", bus_m.out_valid, 0);

        // Basic capture, held without consuming; first instance gets AA, second 55.
        send_word(8'hAA, 1, 2, 1);
        pop_check("cap_aa");
        chk("cap_ovr", bus_m.overrun, 0);
        chk("cap_cnt", bus_m.bit_cnt, 0);

        // Partial word then a two-cycle reset.
        send_bits(8'h3C, 0, 3, 1, 3);
        chk("part_cnt", bus_m.bit_cnt, 4);
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        q_exp.delete();
        chk("rst_par", bus_m.par_out, 0);
        chk("rst_valid", bus_m.out_valid, 0);
        chk("rst_ovr", bus_m.overrun, 0);
        chk("rst_cnt", bus_m.bit_cnt, 0);

        // Clock inhibit for 3 cycles after bit 4.
        send_bits(8'hAA, 0, 3, 1, 3);
        for (int i = 0; i < 3; i++) begin
            ser_in = 1'($urandom); shift_en = 1'b0; tick();
            chk("inh_cnt", bus_m.bit_cnt, 4);
        end
        chk("inh_valid", bus_m.out_valid, 0);
        send_bits(8'hAA, 4, 7, 0, 2);
        q_exp.push_back({1'b0, 8'hAA});
        pop_check("inh");
        consume();
        chk("inh_drain", bus_m.out_valid, 0);

        // Back-to-back under backpressure: second word is dropped.
        send_word(8'hAA, 1, 2, 1);
        send_word(8'h3C, 0, 2, 0);
        pop_check("bp_keep");
        chk("bp_ovr", bus_m.overrun, 1);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("bp_clr", bus_m.overrun, 0);
        chk("bp_held", bus_m.out_valid, 1);
        // Drop coinciding with clr_ovr: the set wins.
        clr_ovr = 1'b1;
        send_word(8'h0F, 0, 2, 0);
        clr_ovr = 1'b0;
        chk("setwins_ovr", bus_m.overrun, 1);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        consume();
        chk("bp_drain", bus_m.out_valid, 0);

        // Drain on the completion cycle of the next word: reload, no overrun.
        send_word(8'hAA, 1, 2, 1);
        send_bits(8'h3C, 0, 6, 0, 3);
        pop_check("bp2_first");
        out_ready = 1'b1;
        send_bits(8'h3C, 7, 7, 0, 2);
        q_exp.push_back({1'b0, 8'h3C});
        pop_check("bp2_second");
        chk("bp2_ovr", bus_m.overrun, 0);
        tick(); out_ready = 1'b0;
        chk("bp2_drain", bus_m.out_valid, 0);

        // Resync after 5 bits: only the new word appears.
        send_bits(8'hFF, 0, 4, 1, 3);
        chk("resync_cnt", bus_m.bit_cnt, 5);
        send_word(8'hF0, 1, 2, 1);
        pop_check("resync");
        consume();
        chk("resync_drain", bus_m.out_valid, 0);

        // Restart coinciding with the completing bit discards the old word.
        send_bits(8'h55, 0, 6, 1, 3);
        chk("coin_cnt", bus_m.bit_cnt, 7);
        send_word(8'h81, 1, 2, 1);
        pop_check("coin");
        consume();

`ifdef PARITY_CHECK_EN
        // Parity: AA with 1 is an error, with 0 is clean.
        send_word(8'hAA, 1, 1, 1);
        pop_check("par_bad");
        consume();
        send_word(8'hAA, 1, 0, 1);
        pop_check("par_good");
        consume();
        // frame_start in PARITY discards the pending word.
        send_bits(8'h55, 0, 7, 1, 3);
        chk("par_cnt", bus_m.bit_cnt, 8);
        send_word(8'h42, 1, 2, 1);
        pop_check("par_resync");
        consume();
`endif

        // A few random words, each drained.
        for (int i = 0; i < 4; i++) begin
            logic [7:0] w;
            w = 8'($urandom);
            send_word(w, i == 0, 2, 1);
            pop_check("rand");
            consume();
        end
        for (int i = 0; i < 3; i++) tick();
        chk("end_valid", bus_m.out_valid, 0);
        chk("end_ovr", bus_m.overrun, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
